// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and issue counter.
// Optional halt-on-self-branch detection is built when FETCH_HALT_DETECT_EN is defined.
module fetch_stage #(
    parameter int unsigned          ADDR_W       = 32,
    parameter int unsigned          INSTR_W      = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC     = '0,
    parameter logic [INSTR_W-1:0]   NOP_INSTR    = 32'hE000_0000,
    parameter int unsigned          DRAIN_CYCLES = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                freeze,
    input  logic                branch_taken,
    input  logic [ADDR_W-1:0]   branch_addr,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [INSTR_W-1:0]  imem_instr,
    output logic [INSTR_W-1:0]  id_instr,
    output logic [ADDR_W-1:0]   id_pc,
    output logic                id_valid,
    output logic [31:0]         fetch_count,
    output logic                halted
);

    if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 7) begin : g_drain_range
        $error("DRAIN_CYCLES must fit the 3-bit drain counter (1..7)");
    end

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] id_instr_q, id_instr_d;
    logic [ADDR_W-1:0]  id_pc_q, id_pc_d;
    logic               id_valid_q, id_valid_d;
    logic [31:0]        fcnt_q, fcnt_d;
    logic [ADDR_W-1:0]  pc_plus4;
    logic [ADDR_W-1:0]  branch_tgt;

    assign pc_plus4   = pc_q + ADDR_W'(4);
    // Redirect targets are forced onto a word boundary.
    assign branch_tgt = branch_addr & ~ADDR_W'(3);

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {RUN, HALT_PEND, HALT} state_t;
    localparam logic [INSTR_W-1:0] SELF_BRANCH = 32'hEAFF_FFFF;

    state_t     state_q, state_d;
    logic [2:0] drain_q, drain_d;

    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        fcnt_d     = fcnt_q;
        state_d    = state_q;
        drain_d    = drain_q;
        case (state_q)
            RUN: begin
                if (branch_taken) begin
                    pc_d       = branch_tgt;
                    id_instr_d = NOP_INSTR;
                    id_pc_d    = '0;
                    id_valid_d = 1'b0;
                end else if (!freeze) begin
                    id_instr_d = imem_instr;
                    id_pc_d    = pc_plus4;
                    id_valid_d = 1'b1;
                    fcnt_d     = fcnt_q + 32'd1;
                    // A branch-to-self parks the PC on its own address.
                    if (imem_instr == SELF_BRANCH) begin
                        state_d = HALT_PEND;
                        drain_d = '0;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            HALT_PEND: begin
                if (branch_taken) begin
                    pc_d       = branch_tgt;
                    id_instr_d = NOP_INSTR;
                    id_pc_d    = '0;
                    id_valid_d = 1'b0;
                    drain_d    = '0;
                    state_d    = RUN;
                end else if (!freeze) begin
                    id_instr_d = NOP_INSTR;
                    id_pc_d    = '0;
                    id_valid_d = 1'b0;
                    drain_d    = drain_q + 3'd1;
                    if ({1'b0, drain_q} + 4'd1 >= 4'(DRAIN_CYCLES)) begin
                        state_d = HALT;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    assign halted = (state_q == HALT);
`else
    always_comb begin
        pc_d       = pc_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        fcnt_d     = fcnt_q;
        if (branch_taken) begin
            pc_d       = branch_tgt;
            id_instr_d = NOP_INSTR;
            id_pc_d    = '0;
            id_valid_d = 1'b0;
        end else if (!freeze) begin
            pc_d       = pc_plus4;
            id_instr_d = imem_instr;
            id_pc_d    = pc_plus4;
            id_valid_d = 1'b1;
            fcnt_d     = fcnt_q + 32'd1;
        end
    end

    assign halted = 1'b0;
`endif

    // IF -> ID register boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            fcnt_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = fcnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then random freeze/branch/reset traffic
// compared every cycle against a cycle-level behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP    = 32'hE000_0000;
    localparam logic [31:0] SELFB  = 32'hEAFF_FFFF;
    localparam int          DRAIN  = 3;
`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_valid;
    logic [31:0] fetch_count;
    logic        halted;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state: mode 0 = running, 1 = draining toward halt, 2 = halted
    logic [31:0] m_pc, m_instr, m_idpc, m_cnt;
    logic        m_valid;
    int          m_mode, m_drain;

    fetch_stage #(
        .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0),
        .NOP_INSTR(32'hE000_0000), .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .id_instr(id_instr), .id_pc(id_pc), .id_valid(id_valid),
        .fetch_count(fetch_count), .halted(halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0)   return 32'hE3A0_0014;
        if (a == 32'd192) return SELFB;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rst, input bit frz, input bit br, input logic [31:0] ba);
        logic [31:0] w;
        if (rst) begin
            m_pc = 0; m_instr = NOP; m_idpc = 0; m_valid = 0; m_cnt = 0;
            m_mode = 0; m_drain = 0;
        end else if (m_mode == 2) begin
        end else if (br) begin
            m_pc = {ba[31:2], 2'b00}; m_instr = NOP; m_idpc = 0; m_valid = 0;
            m_mode = 0; m_drain = 0;
        end else if (frz) begin
        end else if (m_mode == 1) begin
            m_instr = NOP; m_idpc = 0; m_valid = 0;
            m_drain++;
            if (m_drain >= DRAIN) m_mode = 2;
        end else begin
            w = mem_word(m_pc);
            m_instr = w; m_idpc = m_pc + 4; m_valid = 1; m_cnt = m_cnt + 1;
            if (HALT_EN && w == SELFB) begin
                m_mode = 1; m_drain = 0;
            end else begin
                m_pc = m_pc + 4;
            end
        end
    endtask

    task automatic cyc(input bit rst, input bit frz, input bit br, input logic [31:0] ba);
        rst_n = ~rst; freeze = frz; branch_taken = br; branch_addr = ba;
        model_step(rst, frz, br, ba);
        @(posedge clk);
        #1;
        check_eq("pc", imem_addr, m_pc);
        check_eq("id_instr", id_instr, m_instr);
        check_eq("id_pc", id_pc, m_idpc);
        check_eq("id_valid", 32'(id_valid), 32'(m_valid));
        check_eq("fetch_count", fetch_count, m_cnt);
        check_eq("halted", 32'(halted), 32'(m_mode == 2));
    endtask

    task automatic adv(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    initial begin
        // reset and free run from 0
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        check_eq("rst_pc", imem_addr, 32'd0);
        check_eq("rst_instr", id_instr, NOP);
        check_eq("rst_valid", 32'(id_valid), 32'd0);
        check_eq("rst_cnt", fetch_count, 32'd0);
        adv(1);
        check_eq("first_instr", id_instr, 32'hE3A0_0014);
        check_eq("first_idpc", id_pc, 32'd4);
        check_eq("first_valid", 32'(id_valid), 32'd1);
        adv(4);
        check_eq("run5_pc", imem_addr, 32'd20);
        check_eq("run5_cnt", fetch_count, 32'd5);

        // freeze at pc=8
        cyc(1, 0, 0, 0);
        adv(2);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0);
        check_eq("frz_pc", imem_addr, 32'd8);
        check_eq("frz_cnt", fetch_count, 32'd2);
        adv(1);
        check_eq("unfrz_pc", imem_addr, 32'd12);
        check_eq("unfrz_idpc", id_pc, 32'd12);

        // branch overrides freeze, low bits dropped
        cyc(0, 1, 1, 32'h0000_0093);
        check_eq("br_pc", imem_addr, 32'h90);
        check_eq("br_instr", id_instr, NOP);
        check_eq("br_valid", 32'(id_valid), 32'd0);
        check_eq("br_cnt", fetch_count, 32'd3);

        // address wrap
        cyc(0, 0, 1, 32'hFFFF_FFFC);
        adv(1);
        check_eq("wrap_pc", imem_addr, 32'd0);
        check_eq("wrap_idpc", id_pc, 32'd0);
        check_eq("wrap_valid", 32'(id_valid), 32'd1);

        // reset mid-stream, also while frozen and branching
        cyc(1, 0, 0, 0);
        adv(10);
        check_eq("pre_rst_pc", imem_addr, 32'd40);
        cyc(1, 1, 1, 32'h100);
        check_eq("mid_rst_pc", imem_addr, 32'd0);
        check_eq("mid_rst_cnt", fetch_count, 32'd0);
        check_eq("mid_rst_valid", 32'(id_valid), 32'd0);

        // self-branch word at 192
        cyc(0, 0, 1, 32'd192);
        adv(1);
        check_eq("selfb_instr", id_instr, SELFB);
        for (int i = 0; i < DRAIN; i++) cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 32'h200);
        adv(2);
        check_eq("halt_flag", 32'(halted), HALT_EN ? 32'd1 : 32'd0);
        if (HALT_EN) check_eq("halt_pc", imem_addr, 32'd192);

        // cancelled halt: branch on the 2nd drain cycle
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 32'd192);
        adv(2);
        cyc(0, 0, 1, 32'd156);
        check_eq("cancel_pc", imem_addr, 32'd156);
        check_eq("cancel_halted", 32'(halted), 32'd0);
        adv(3);

        // random traffic
        for (int i = 0; i < 2000; i++) begin
            bit r, f, b;
            logic [31:0] a;
            r = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: a = $urandom();
                1: a = 32'd180 + 32'($urandom_range(0, 3));
                2: a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                default: a = 32'($urandom_range(0, 255));
            endcase
            cyc(r, f, b, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the ARM-subset pipeline, directly upstream of the byte-addressed, combinational instruction memory.
- Holds the PC and drives the memory address. Captures the returned word into the IF/ID pipeline register with a valid bit.
- Handles freeze (hazard unit) and branch redirect/flush (from EXE).
- Counts issued instructions.

Parameters:
- ADDR_W, 32, PC / memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 0, PC value loaded at reset
- NOP_INSTR, 32'hE000_0000, bubble word (AND R0,R0,R0, cond AL)
- DRAIN_CYCLES, 3, cycles in HALT_PEND before HALT (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- freeze  in  1  hold PC and IF/ID register
- branch_taken  in  1  redirect PC and flush IF/ID
- branch_addr  in  ADDR_W  redirect target
- imem_addr  out  ADDR_W  address to instruction memory (= pc)
- imem_instr  in  INSTR_W  word returned combinationally for imem_addr
- id_instr  out  INSTR_W  registered instruction to ID
- id_pc  out  ADDR_W  registered pc+4 of id_instr
- id_valid  out  1  id_instr is a real fetched instruction
- fetch_count  out  32  number of instructions issued to ID
- halted  out  1  fetch stopped on self-branch (0 without optional feature)

Behaviour:
- One clock: clk. Reset is synchronous, active-low: rst_n sampled only on the rising clk edge.
- Reset values:
  - pc = RESET_PC
  - id_instr = NOP_INSTR, id_pc = 0, id_valid = 0
  - fetch_count = 0, halted = 0, state = RUN
- imem_addr = pc combinationally. Instruction memory latency is 0, so the word fetched at cycle N appears on id_instr after edge N+1.
- Edge priority: reset > branch_taken > freeze > normal advance.
- branch_taken:
  - pc <= {branch_addr[ADDR_W-1:2], 2'b00}, low bits forced to zero.
  - id_instr <= NOP_INSTR, id_valid <= 0, id_pc <= 0.
  - fetch_count unchanged.
  - Overrides freeze in the same cycle.
- freeze (no branch): pc, id_instr, id_pc, id_valid and fetch_count all hold.
- Normal advance:
  - pc <= pc + 4, modulo 2^ADDR_W; 32'hFFFF_FFFC wraps to 0.
  - id_instr <= imem_instr, id_pc <= pc + 4, id_valid <= 1.
  - fetch_count <= fetch_count + 1, wrapping at 2^32.
- PC is always word-aligned; pc[1:0] is never nonzero.
- Reset asserted mid-freeze or mid-branch wins unconditionally. The next cycle fetches from RESET_PC.
- No other sequential state exists without the optional feature.

Optional Feature:
- Macro: FETCH_HALT_DETECT_EN.
- Defined — FSM states RUN, HALT_PEND, HALT; 3-bit drain counter.
- RUN to HALT_PEND: on a normal advance whose imem_instr == 32'hEAFFFFFF (B to self, AL). That word is issued to ID as usual.
- HALT_PEND:
  - pc holds at the halt address; id_instr <= NOP_INSTR, id_valid <= 0 each cycle.
  - freeze keeps id regs held.
  - Drain counter increments on every non-frozen cycle.
- HALT_PEND exits:
  - branch_taken: apply the normal redirect, clear the counter, go to RUN (wrong-path halt cancelled).
  - Counter reaches DRAIN_CYCLES with no branch: go to HALT.
- HALT:
  - halted = 1; pc held; id_valid = 0.
  - branch_taken and freeze ignored.
  - Only reset leaves HALT.
- Undefined — 32'hEAFFFFFF fetches like any word; halted tied to 0; no FSM logic synthesized.

Test Plan:
- Reset, release, 5 free-running cycles, imem returns 32'hE3A00014 at 0 -> first edge: id_instr=E3A00014, id_pc=4, id_valid=1; after 5 edges: pc=20, fetch_count=5.
- Freeze held 3 cycles at pc=8 -> pc stays 8, id regs and fetch_count unchanged; on release the next edge yields pc=12, id_pc=12.
- branch_taken=1, branch_addr=32'h0000_0093, with freeze=1 the same cycle -> pc=32'h90, id_instr=E0000000, id_valid=0, fetch_count unchanged.
- pc forced to 32'hFFFF_FFFC via branch, then one advance -> pc=0, id_pc=0, id_valid=1.
- rst_n low for one edge mid-stream at pc=40, fetch_count=10 -> pc=0, fetch_count=0, id_valid=0.
- With FETCH_HALT_DETECT_EN, EAFFFFFF at 192:
  - No branch -> after 3 drain edges halted=1, pc=192 forever; a later branch_taken has no effect.
  - Repeat with branch_taken (addr 156) on the 2nd drain cycle -> state RUN, pc=156, halted=0.
